// File: rtl/maxpool_2x2_stage_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : maxpool_2x2_stage_if
// Purpose  : Handshake bundle between the systolic array, the 2x2 max-pool
//            stage and the OFM RAM writer.
// Revision : 1.0 - initial release
// ============================================================================
interface maxpool_2x2_stage_if #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 12
);
    localparam int c_IN_W  = SYSTOLIC_SIZE * 2 * DATA_WIDTH;
    localparam int c_OUT_W = (SYSTOLIC_SIZE / 2) * 2 * DATA_WIDTH;

    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [c_IN_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [c_OUT_W-1:0]    out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  done;

    // Producer/consumer side: drives start, input segments and out_ready.
    modport master (
        output start,
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_addr,
        input  done
    );

    // Pooling stage side.
    modport slave (
        input  start,
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_addr,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/maxpool_2x2_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : maxpool_2x2_stage
// Purpose  : Signed 2x2 / stride-2 max pooling between the systolic array and
//            the OFM RAM. Even rows are pre-pooled horizontally into a one-row
//            line buffer; odd rows combine with it and emit an addressed beat.
// Options  : define MAXPOOL_RELU_EN to clamp negative pooled lanes to zero.
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_2x2_stage #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int OFM_SIZE      = 32,
    parameter int NO_FILTER     = 16,
    parameter int ADDR_WIDTH    = 12
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    maxpool_2x2_stage_if.slave     bus
);

    localparam int c_EW        = 2 * DATA_WIDTH;
    localparam int c_LANES_OUT = SYSTOLIC_SIZE / 2;
    localparam int c_OW        = c_LANES_OUT * c_EW;
    localparam int c_SEGS      = OFM_SIZE / SYSTOLIC_SIZE;
    localparam int c_HALF      = OFM_SIZE / 2;
    localparam int c_HALF_SQ   = c_HALF * c_HALF;
    localparam int c_SEG_W     = (c_SEGS > 1) ? $clog2(c_SEGS) : 1;
    localparam int c_ROW_W     = $clog2(OFM_SIZE);
    localparam int c_FILT_W    = (NO_FILTER > 1) ? $clog2(NO_FILTER) : 1;

    // Elaboration-time guards on the geometry the datapath relies on.
    if (SYSTOLIC_SIZE % 2 != 0) begin : g_bad_systolic
        $error("maxpool_2x2_stage: SYSTOLIC_SIZE must be even");
    end
    if ((OFM_SIZE % 2 != 0) || (OFM_SIZE % SYSTOLIC_SIZE != 0)) begin : g_bad_ofm
        $error("maxpool_2x2_stage: OFM_SIZE must be even and a multiple of SYSTOLIC_SIZE");
    end
    if ((2 ** ADDR_WIDTH) < (c_HALF_SQ * NO_FILTER)) begin : g_bad_addr
        $error("maxpool_2x2_stage: ADDR_WIDTH too small for the pooled map");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_SEG_W-1:0]    r_seg;
    logic [c_ROW_W-1:0]    r_row;
    logic [c_FILT_W-1:0]   r_filt;
    logic                  r_out_valid;
    logic [c_OW-1:0]       r_out_data;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic                  r_done;

    logic [c_OW-1:0]       r_linebuf [c_SEGS];

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_seg_last;
    logic                  w_row_last;
    logic                  w_filt_last;
    logic [c_OW-1:0]       w_lb_entry;
    logic [c_OW-1:0]       w_h_bus;
    logic [c_OW-1:0]       w_pool_bus;
    logic [ADDR_WIDTH-1:0] w_addr;

    // A new segment may enter whenever the output register is free or is
    // being drained this very cycle, which gives bubble-free streaming.
    assign w_in_ready  = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;

    assign w_seg_last  = (r_seg  == c_SEG_W'(c_SEGS - 1));
    assign w_row_last  = (r_row  == c_ROW_W'(OFM_SIZE - 1));
    assign w_filt_last = (r_filt == c_FILT_W'(NO_FILTER - 1));

    assign w_lb_entry  = r_linebuf[r_seg];

    assign w_addr = ADDR_WIDTH'(32'(r_filt) * 32'(c_HALF_SQ)
                              + 32'(r_row >> 1) * 32'(c_HALF)
                              + 32'(r_seg) * 32'(c_LANES_OUT));

    for (genvar j = 0; j < c_LANES_OUT; j++) begin : g_lane
        logic signed [c_EW-1:0] w_a;
        logic signed [c_EW-1:0] w_b;
        logic signed [c_EW-1:0] w_h;
        logic signed [c_EW-1:0] w_l;
        logic signed [c_EW-1:0] w_m;
        logic signed [c_EW-1:0] w_p;

        assign w_a = bus.in_data[(2 * j) * c_EW +: c_EW];
        assign w_b = bus.in_data[(2 * j + 1) * c_EW +: c_EW];
        assign w_h = (w_a >= w_b) ? w_a : w_b;
        assign w_l = w_lb_entry[j * c_EW +: c_EW];
        assign w_m = (w_h >= w_l) ? w_h : w_l;
`ifdef MAXPOOL_RELU_EN
        assign w_p = w_m[c_EW-1] ? '0 : w_m;
`else
        assign w_p = w_m;
`endif
        assign w_h_bus[j * c_EW +: c_EW]    = w_h;
        assign w_pool_bus[j * c_EW +: c_EW] = w_p;
    end

    // Line buffer content is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept && !r_row[0]) begin
            r_linebuf[r_seg] <= w_h_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= S_IDLE;
            r_seg       <= '0;
            r_row       <= '0;
            r_filt      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_seg   <= '0;
                        r_row   <= '0;
                        r_filt  <= '0;
                    end
                end

                S_RUN: begin
                    if (w_accept) begin
                        if (r_row[0]) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_pool_bus;
                            r_out_addr  <= w_addr;
                        end
                        if (w_seg_last) begin
                            r_seg <= '0;
                            if (w_row_last) begin
                                r_row <= '0;
                                if (w_filt_last) begin
                                    r_filt  <= '0;
                                    r_state <= S_FLUSH;
                                end else begin
                                    r_filt <= r_filt + c_FILT_W'(1);
                                end
                            end else begin
                                r_row <= r_row + c_ROW_W'(1);
                            end
                        end else begin
                            r_seg <= r_seg + c_SEG_W'(1);
                        end
                    end
                end

                S_FLUSH: begin
                    // The last beat of a run is always an odd row, so this
                    // waits for the writer to take that final pooled beat.
                    if (!r_out_valid || bus.out_ready) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_out_addr;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_2x2_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_maxpool_2x2_stage
// Purpose  : Self-checking bench for maxpool_2x2_stage: directed single-window
//            table, backpressure, full-run addressing and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_2x2_stage;

    localparam int SYS    = 16;
    localparam int DW     = 8;
    localparam int OFM    = 32;
    localparam int NF     = 16;
    localparam int AW     = 12;
    localparam int EW     = 2 * DW;
    localparam int LO     = SYS / 2;
    localparam int IW     = SYS * EW;
    localparam int OW     = LO * EW;
    localparam int SEGS   = OFM / SYS;
    localparam int HALF   = OFM / 2;
    localparam int NBEATS = NF * OFM * SEGS;
    localparam int NOUT   = NF * HALF * SEGS;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    maxpool_2x2_stage_if #(.SYSTOLIC_SIZE(SYS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    maxpool_2x2_stage #(
        .SYSTOLIC_SIZE(SYS),
        .DATA_WIDTH   (DW),
        .OFM_SIZE     (OFM),
        .NO_FILTER    (NF),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total    = 0;
    int bad      = 0;
    int mon_idx  = 0;
    int done_cnt = 0;
    bit mon_en   = 1'b0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] gen(input int f, input int r, input int s, input int lane);
        logic [31:0] h;
        h = (32'(f) * 32'd1009 + 32'(r) * 32'd131 + 32'(s * SYS + lane) * 32'd17 + 32'd5)
            * 32'h9E3779B1;
        return h[31:16];
    endfunction

    function automatic logic signed [EW-1:0] smax(input logic signed [EW-1:0] a,
                                                  input logic signed [EW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [IW-1:0] build_beat(input int f, input int r, input int s);
        logic [IW-1:0] v;
        for (int k = 0; k < SYS; k++) v[k * EW +: EW] = gen(f, r, s, k);
        return v;
    endfunction

    // Golden pooled beat straight from the element generator (no line buffer).
    function automatic logic [OW-1:0] exp_beat(input int f, input int pr, input int s);
        logic [OW-1:0]          v;
        logic signed [EW-1:0]   m;
        for (int j = 0; j < LO; j++) begin
            m = smax(smax(gen(f, 2 * pr, s, 2 * j),     gen(f, 2 * pr, s, 2 * j + 1)),
                     smax(gen(f, 2 * pr + 1, s, 2 * j), gen(f, 2 * pr + 1, s, 2 * j + 1)));
`ifdef MAXPOOL_RELU_EN
            if (m < 0) m = '0;
`endif
            v[j * EW +: EW] = m;
        end
        return v;
    endfunction

    // Output monitor: every accepted beat is checked in issue order.
    always @(negedge clk) begin
        int f, pr, s;
        if (mon_en && bus.out_valid && bus.out_ready) begin
            f  = mon_idx / (HALF * SEGS);
            pr = (mon_idx / SEGS) % HALF;
            s  = mon_idx % SEGS;
            chk("beat_data", bus.out_data, exp_beat(f, pr, s));
            chk("beat_addr", OW'(bus.out_addr), OW'(f * HALF * HALF + pr * HALF + s * LO));
            if (f == 3 && pr == 2 && s == 1) chk("addr_808", OW'(bus.out_addr), OW'(808));
            mon_idx++;
        end
        if (mon_en && bus.done) begin
            done_cnt++;
            chk("done_after_last", OW'(mon_idx), OW'(NOUT));
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [IW-1:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout: got 0 expected 1 within 100 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    // Stall the writer with a pending beat (filt0, pair0, seg1) for 5 cycles.
    task automatic backpressure(input logic [IW-1:0] d);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready",  OW'(bus.in_ready),  OW'(0));
            chk("bp_out_valid", OW'(bus.out_valid), OW'(1));
            chk("bp_out_data",  bus.out_data,       exp_beat(0, 0, 1));
            chk("bp_out_addr",  OW'(bus.out_addr),  OW'(LO));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
    endtask

    task automatic run_frame(input int stop_after, input bit bp);
        pulse_start();
        for (int b = 0; b < NBEATS; b++) begin
            if (b == stop_after) break;
            if (bp && b == 4) backpressure(build_beat(0, 2, 0));
            send_beat(build_beat(b / (OFM * SEGS), (b / SEGS) % OFM, b % SEGS));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("done_once",  OW'(done_cnt), OW'(1));
        chk("beat_count", OW'(mon_idx),  OW'(NOUT));
        chk("idle_ready", OW'(bus.in_ready), OW'(0));
    endtask

    typedef struct {
        logic signed [EW-1:0] a, b, c, d;
        logic signed [EW-1:0] exp_plain;
        logic signed [EW-1:0] exp_relu;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [IW-1:0]        beat;
        logic [OW-1:0]        exp_out;
        logic signed [EW-1:0] e;

        vt[0] = '{a:  16'sd3,     b: -16'sd7,     c:  16'sd5,     d:  16'sd2,     exp_plain:  16'sd5,     exp_relu: 16'sd5};
        vt[1] = '{a: -16'sd4,     b: -16'sd4,     c: -16'sd4,     d: -16'sd4,     exp_plain: -16'sd4,     exp_relu: 16'sd0};
        vt[2] = '{a: -16'sd1,     b: -16'sd2,     c: -16'sd3,     d: -16'sd100,   exp_plain: -16'sd1,     exp_relu: 16'sd0};
        vt[3] = '{a:  16'sd32767, b: -16'sd32768, c:  16'sd0,     d:  16'sd1,     exp_plain:  16'sd32767, exp_relu: 16'sd32767};
        vt[4] = '{a: -16'sd32768, b: -16'sd32768, c: -16'sd32768, d: -16'sd32767, exp_plain: -16'sd32767, exp_relu: 16'sd0};
        vt[5] = '{a:  16'sd10,    b:  16'sd20,    c:  16'sd30,    d:  16'sd25,    exp_plain:  16'sd30,    exp_relu: 16'sd30};
        vt[6] = '{a:  16'sd7,     b:  16'sd7,     c:  16'sd7,     d:  16'sd7,     exp_plain:  16'sd7,     exp_relu: 16'sd7};
        vt[7] = '{a: -16'sd5,     b:  16'sd100,   c: -16'sd200,   d:  16'sd99,    exp_plain:  16'sd100,   exp_relu: 16'sd100};

        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset values.
        apply_reset(2);
        chk("rst_in_ready",  OW'(bus.in_ready),  OW'(0));
        chk("rst_out_valid", OW'(bus.out_valid), OW'(0));
        chk("rst_out_data",  bus.out_data,       OW'(0));
        chk("rst_out_addr",  OW'(bus.out_addr),  OW'(0));
        chk("rst_done",      OW'(bus.done),      OW'(0));

        // in_valid while idle is not consumed.
        bus.in_valid = 1'b1;
        bus.in_data  = build_beat(0, 1, 0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", OW'(bus.in_ready), OW'(0));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("idle_out_valid", OW'(bus.out_valid), OW'(0));

        // Single-window table; window j placed on lane pair 2j/2j+1.
        for (int i = 0; i < 8; i++) begin
            apply_reset(1);
            pulse_start();
            chk("start_in_ready", OW'(bus.in_ready), OW'(1));
            beat = '0;
            beat[(2 * i) * EW +: EW]     = vt[i].a;
            beat[(2 * i + 1) * EW +: EW] = vt[i].b;
            send_beat(beat);
            send_beat('0);
            chk("even_no_out", OW'(bus.out_valid), OW'(0));
            beat = '0;
            beat[(2 * i) * EW +: EW]     = vt[i].c;
            beat[(2 * i + 1) * EW +: EW] = vt[i].d;
            send_beat(beat);
`ifdef MAXPOOL_RELU_EN
            e = vt[i].exp_relu;
`else
            e = vt[i].exp_plain;
`endif
            exp_out = '0;
            exp_out[i * EW +: EW] = e;
            chk("win_valid", OW'(bus.out_valid), OW'(1));
            chk("win_data",  bus.out_data,       exp_out);
            chk("win_addr",  OW'(bus.out_addr),  OW'(0));
        end
        apply_reset(1);

        // Mid-run reset after 100 beats.
        mon_idx  = 0;
        done_cnt = 0;
        mon_en   = 1'b1;
        run_frame(100, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", OW'(bus.out_valid), OW'(0));
        chk("abort_in_ready",  OW'(bus.in_ready),  OW'(0));
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done",   OW'(done_cnt), OW'(0));
        chk("abort_beats",     OW'(mon_idx),  OW'(50));

        // Full golden run with a backpressure window.
        mon_idx  = 0;
        done_cnt = 0;
        run_frame(-1, 1'b1);
        wait_done();
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/maxpool_2x2_stage.md
Name: maxpool_2x2_stage

Overview:
- Consumes 16-bit convolution results from the systolic array, one SYSTOLIC_SIZE-wide row segment per beat.
- Performs signed 2x2/stride-2 max pooling and emits SYSTOLIC_SIZE/2 pooled values per write beat, each beat with an element address.
- Sits between the systolic array output and the OFM dual-port RAM (dpram_ofm).
- Uses a one-row line buffer holding horizontally pre-pooled even rows.

Parameters:
- SYSTOLIC_SIZE, 16, output lanes per input beat; must be even.
- DATA_WIDTH, 8, base width; every element is 2*DATA_WIDTH bits, signed.
- OFM_SIZE, 32, conv output height/width; even, and a multiple of SYSTOLIC_SIZE.
- NO_FILTER, 16, number of output channels processed per run.
- ADDR_WIDTH, 12, OFM RAM element address width; must cover (OFM_SIZE/2)^2*NO_FILTER.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  reset; synchronous, active-high (1 = reset). Port name kept per codebase, polarity fixed as stated.
- start  in  1  one-cycle pulse; arms a run from IDLE.
- in_valid  in  1  input segment valid.
- in_ready  out  1  stage accepts the segment this cycle.
- in_data  in  SYSTOLIC_SIZE*2*DATA_WIDTH  lane k at bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH]; lane 0 = leftmost column.
- out_valid  out  1  pooled beat valid.
- out_ready  in  1  OFM writer accepts the beat.
- out_data  out  (SYSTOLIC_SIZE/2)*2*DATA_WIDTH  pooled lane j = max of lanes 2j, 2j+1 over two rows.
- out_addr  out  ADDR_WIDTH  element address of pooled lane 0.
- done  out  1  one-cycle pulse after the final pooled beat is accepted.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_addr=0, done=0. All counters cleared, FSM to IDLE, line buffer contents don't-care.
- FSM states:
  - IDLE: in_ready=0. start moves to RUN and clears counters.
  - RUN: accepts input; start is ignored.
  - FLUSH: waits for the last out beat to be accepted, then pulses done for 1 cycle and returns to IDLE.
- Input order: filter-major, then conv row 0..OFM_SIZE-1, then segment 0..SEGS-1, where SEGS=OFM_SIZE/SYSTOLIC_SIZE.
- Counters seg, row, filt advance on each accepted beat (in_valid & in_ready) with nested wrap.
- Handshake: in_ready = RUN & (!out_valid | out_ready). out_valid holds with stable data/addr until out_ready.
- Horizontal pool: h[j] = signed max(lane 2j, lane 2j+1). Equal values give the same result either way.
- Even row: h is written to line buffer entry seg. No output.
- Odd row: out_data[j] = signed max(h[j], linebuf[seg][j]). out_valid rises the cycle after acceptance (latency 1).
- out_addr = filt*(OFM_SIZE/2)^2 + (row>>1)*(OFM_SIZE/2) + seg*(SYSTOLIC_SIZE/2), computed from the pre-increment counters.
- Last beat (filt=NO_FILTER-1, row=OFM_SIZE-1, seg=SEGS-1): the FSM enters FLUSH. in_ready=0 from then on.
- Simultaneous out handshake and new input acceptance in the same cycle: the new beat replaces the output register with no bubble.
- rst_n asserted mid-run: abort immediately. No done pulse, out_valid=0 the next cycle.
- in_valid in IDLE: ignored, data not consumed.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: each pooled lane is clamped at 0 before registering (negative becomes 0). This is one extra mux per lane and adds no latency.
- Undefined: signed results pass unmodified, so negative maxima are written as-is.

Test Plan:
- Reset: rst_n=1 for 2 cycles -> all outputs 0 and in_ready=0. After start, in_ready=1 on the next cycle.
- Single window: filt 0, row 0 seg 0 lanes0..1 = 3,-7; row 1 seg 0 lanes0..1 = 5,2 -> out_data lane0=5, out_addr=0, out_valid one cycle after the row-1 beat.
- Negative window: all four = -4 (0xFFFC) -> lane0 = 0xFFFC. With MAXPOOL_RELU_EN -> lane0 = 0.
- Addressing: full run with default parameters -> 512 out beats. The beat for filt=3, row=5, seg=1 has out_addr = 3*256 + 2*16 + 8 = 808. done pulses exactly once, after the 512th accept.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data/out_addr stable. On release, no beat is lost or duplicated.
- Mid-run reset: assert rst_n after 100 beats -> out_valid=0 and in_ready=0 the next cycle, no done. A new start followed by a full run produces the golden results.
